// File: rtl/divmmc_automap_mux.sv
// DivMMC paging merged onto the +3 ROM-emulation path: port 0xE3 control register,
// M1-driven automapper FSM and the final SRAM/EEPROM/ROMCS select decode.
`timescale 1ns/1ps
module divmmc_automap_mux #(
    parameter logic [7:0] E3_PORT   = 8'hE3,
    parameter int         BANK_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          a,
    input  logic [7:0]           din,
    input  logic                 mreq_n,
    input  logic                 iorq_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic                 m1_n,
    input  logic                 rom3e_cs,
    input  logic [5:0]           rom3e_hiaddr,
    input  logic [1:0]           banco_rom,
    input  logic                 allramplus3,
    output logic                 sram_cs_n,
    output logic                 sram_we_n,
    output logic [5:0]           sram_hiaddr,
    output logic                 eeprom_cs_n,
    output logic                 romcs
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_MAPPED = 2'd2;
    localparam logic [1:0] S_DISARM = 2'd3;

    logic                 r_conmem;
    logic                 r_mapram;
    logic [BANK_BITS-1:0] r_bank;
    logic [1:0]           r_state;
    logic                 r_m1_q;
    logic                 r_iowr_q;

    logic       w_iowr;
    logic       w_e3_wr;
    logic       w_trap_en;
    logic       w_fetch;
    logic       w_entry;
    logic       w_instant;
    logic       w_exit;
    logic       w_m1_rise;
    logic       w_map_active;
    logic       w_mem;
    logic       w_bank3_ro;
    logic [5:0] w_bank_ext;
    logic [1:0] w_state_next;
    logic       w_unused;

    assign w_unused  = &{1'b0, din};
    assign w_iowr    = !iorq_n && !wr_n;
    // A held I/O write strobe spans several clocks; only its first edge loads the register.
    assign w_e3_wr   = w_iowr && !r_iowr_q && (a[7:0] == E3_PORT);
    assign w_trap_en = !allramplus3 && (banco_rom == 2'b11);
    assign w_fetch   = !m1_n && !mreq_n;
    assign w_entry   = w_fetch && ((a == 16'h0000) || (a == 16'h0008) || (a == 16'h0038) ||
                                   (a == 16'h0066) || (a == 16'h04C6) || (a == 16'h0562));
    assign w_instant = w_fetch && (a[15:8] == 8'h3D);
    assign w_exit    = w_fetch && (a[15:3] == 13'h03FF);
    assign w_m1_rise = !r_m1_q && m1_n;

    always_comb begin
        w_state_next = r_state;
        if (w_trap_en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_entry)
                        w_state_next = S_ARMED;
                    else if (w_instant)
                        w_state_next = S_MAPPED;
                end
                S_ARMED: begin
                    if (w_m1_rise)
                        w_state_next = S_MAPPED;
                end
                S_MAPPED: begin
                    if (w_exit)
                        w_state_next = S_DISARM;
                end
                default: begin
                    if (w_entry)
                        w_state_next = S_MAPPED;
                    else if (w_m1_rise)
                        w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conmem <= 1'b0;
            r_mapram <= 1'b0;
            r_bank   <= '0;
            r_state  <= S_IDLE;
            r_m1_q   <= 1'b1;
            r_iowr_q <= 1'b0;
        end else begin
            r_m1_q   <= m1_n;
            r_iowr_q <= w_iowr;
            r_state  <= w_state_next;
            if (w_e3_wr) begin
                r_conmem <= din[7];
                r_mapram <= r_mapram | din[6];
                r_bank   <= din[BANK_BITS-1:0];
            end
        end
    end

    // rst_n gates the instant-map term so reset unmaps without waiting for a clock.
    assign w_map_active = rst_n && (r_conmem || (r_state == S_MAPPED) || (r_state == S_DISARM) ||
                                    ((r_state == S_IDLE) && w_instant && w_trap_en));
    assign w_mem        = !mreq_n && (a[15:14] == 2'b00);
    assign w_bank3_ro   = r_mapram && !r_conmem && (r_bank == BANK_BITS'(3));
    assign w_bank_ext   = 6'(r_bank);

    always_comb begin
        sram_cs_n   = 1'b1;
        sram_we_n   = 1'b1;
        eeprom_cs_n = 1'b1;
        romcs       = 1'b0;
        sram_hiaddr = rom3e_hiaddr;
        if (w_mem) begin
            if (w_map_active) begin
                romcs = 1'b1;
                if (!a[13]) begin
                    if (r_conmem || !r_mapram) begin
                        eeprom_cs_n = rd_n;
                    end else begin
                        sram_cs_n   = 1'b0;
                        sram_hiaddr = 6'd3;
                    end
                end else begin
                    sram_cs_n   = 1'b0;
                    sram_hiaddr = w_bank_ext;
                    sram_we_n   = wr_n || w_bank3_ro;
                end
            end else begin
                sram_cs_n = !rom3e_cs;
                romcs     = rom3e_cs;
            end
        end
    end

endmodule

// File: tb/tb_divmmc_automap_mux.sv
// Directed bench for divmmc_automap_mux: Z80 bus cycles driven by tasks, outputs
// checked as {sram_cs_n, sram_we_n, eeprom_cs_n, romcs, sram_hiaddr}.
`timescale 1ns/1ps
module tb_divmmc_automap_mux;

    localparam logic [5:0] HI = 6'h2A;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [7:0]  din;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic        rom3e_cs;
    logic [5:0]  rom3e_hiaddr;
    logic [1:0]  banco_rom;
    logic        allramplus3;
    logic        sram_cs_n, sram_we_n, eeprom_cs_n, romcs;
    logic [5:0]  sram_hiaddr;
    logic [9:0]  w_outs;
    int          n_checks;
    int          n_fails;

    divmmc_automap_mux #(.E3_PORT(8'hE3), .BANK_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .din(din),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .rom3e_cs(rom3e_cs), .rom3e_hiaddr(rom3e_hiaddr),
        .banco_rom(banco_rom), .allramplus3(allramplus3),
        .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_hiaddr(sram_hiaddr),
        .eeprom_cs_n(eeprom_cs_n), .romcs(romcs)
    );

    assign w_outs = {sram_cs_n, sram_we_n, eeprom_cs_n, romcs, sram_hiaddr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        clk_edge();
    endtask

    task automatic fetch_start(input logic [15:0] addr);
        a = addr; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
    endtask

    task automatic mem_rd(input logic [15:0] addr);
        a = addr; mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        #1;
    endtask

    task automatic mem_wr(input logic [15:0] addr);
        a = addr; mreq_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
        #1;
    endtask

    // OUT cycle with the strobe held over two clock edges.
    task automatic io_wr(input logic [7:0] val);
        a = 16'h12E3; din = val; iorq_n = 1'b0; wr_n = 1'b0;
        clk_edge();
        clk_edge();
        bus_idle();
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL reset_outputs: got %b want %b", w_outs, {4'b1110, HI});
        end
        rom3e_cs = 1'b1;
        #1;
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL reset_bus_idle_romcs: got %b want %b", w_outs, {4'b1110, HI});
        end
        rom3e_cs = 1'b0;
        clk_edge();
        rst_n = 1'b1;
        bus_idle();
    endtask

    task automatic test_e3_edge();
        a = 16'h00E3; din = 8'h85; iorq_n = 1'b0; wr_n = 1'b0;
        clk_edge();
        din = 8'h07;
        clk_edge();
        bus_idle();
        mem_rd(16'h2000);
        n_checks++;
        if (w_outs !== {4'b0111, 6'd5}) begin
            n_fails++; $display("FAIL e3_single_write: got %b want %b", w_outs, {4'b0111, 6'd5});
        end
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1101, HI}) begin
            n_fails++; $display("FAIL conmem_eeprom: got %b want %b", w_outs, {4'b1101, HI});
        end
        bus_idle();
        io_wr(8'h05);
        mem_rd(16'h2000);
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL conmem_cleared: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
    endtask

    task automatic test_entry_trap();
        fetch_start(16'h0038);
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL entry_fetch_pre: got %b want %b", w_outs, {4'b1110, HI});
        end
        clk_edge();
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL entry_fetch_armed: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
        mem_rd(16'h2000);
        n_checks++;
        if (w_outs !== {4'b0111, 6'd5}) begin
            n_fails++; $display("FAIL mapped_bank_read: got %b want %b", w_outs, {4'b0111, 6'd5});
        end
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1101, HI}) begin
            n_fails++; $display("FAIL mapped_eeprom_read: got %b want %b", w_outs, {4'b1101, HI});
        end
        mem_wr(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1111, HI}) begin
            n_fails++; $display("FAIL eeprom_write_ignored: got %b want %b", w_outs, {4'b1111, HI});
        end
        rom3e_cs = 1'b1;
        mem_rd(16'h4000);
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL outside_window: got %b want %b", w_outs, {4'b1110, HI});
        end
        rom3e_cs = 1'b0;
        bus_idle();
    endtask

    task automatic test_exit();
        fetch_start(16'h1FF8);
        n_checks++;
        if (w_outs !== {4'b1101, HI}) begin
            n_fails++; $display("FAIL exit_fetch_pre: got %b want %b", w_outs, {4'b1101, HI});
        end
        clk_edge();
        n_checks++;
        if (w_outs !== {4'b1101, HI}) begin
            n_fails++; $display("FAIL exit_fetch_disarm: got %b want %b", w_outs, {4'b1101, HI});
        end
        bus_idle();
        rom3e_cs = 1'b1;
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b0111, HI}) begin
            n_fails++; $display("FAIL unmapped_rom3e_sel: got %b want %b", w_outs, {4'b0111, HI});
        end
        rom3e_cs = 1'b0;
        #1;
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL unmapped_rom3e_desel: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
    endtask

    task automatic test_instant();
        fetch_start(16'h3D00);
        n_checks++;
        if (w_outs !== {4'b0111, 6'd5}) begin
            n_fails++; $display("FAIL instant_fetch_pre: got %b want %b", w_outs, {4'b0111, 6'd5});
        end
        clk_edge();
        n_checks++;
        if (w_outs !== {4'b0111, 6'd5}) begin
            n_fails++; $display("FAIL instant_fetch_post: got %b want %b", w_outs, {4'b0111, 6'd5});
        end
        bus_idle();
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1101, HI}) begin
            n_fails++; $display("FAIL instant_stays_mapped: got %b want %b", w_outs, {4'b1101, HI});
        end
        bus_idle();
        fetch_start(16'h1FFF);
        clk_edge();
        bus_idle();
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL exit_1fff_unmaps: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
    endtask

    task automatic test_trap_disable();
        banco_rom = 2'b00;
        fetch_start(16'h0000);
        clk_edge();
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL banco0_fetch: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL banco0_no_arm: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
        fetch_start(16'h3D00);
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL banco0_no_instant: got %b want %b", w_outs, {4'b1110, HI});
        end
        clk_edge();
        bus_idle();
        banco_rom = 2'b11; allramplus3 = 1'b1;
        fetch_start(16'h0066);
        clk_edge();
        bus_idle();
        allramplus3 = 1'b0;
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL allram_no_arm: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
    endtask

    task automatic test_mapram();
        io_wr(8'h40);
        io_wr(8'h00);
        fetch_start(16'h0066);
        clk_edge();
        bus_idle();
        mem_rd(16'h0100);
        n_checks++;
        if (w_outs !== {4'b0111, 6'd3}) begin
            n_fails++; $display("FAIL mapram_page3_read: got %b want %b", w_outs, {4'b0111, 6'd3});
        end
        mem_wr(16'h0100);
        n_checks++;
        if (w_outs !== {4'b0111, 6'd3}) begin
            n_fails++; $display("FAIL mapram_page3_ro: got %b want %b", w_outs, {4'b0111, 6'd3});
        end
        bus_idle();
        io_wr(8'h03);
        mem_wr(16'h2000);
        n_checks++;
        if (w_outs !== {4'b0111, 6'd3}) begin
            n_fails++; $display("FAIL mapram_bank3_ro: got %b want %b", w_outs, {4'b0111, 6'd3});
        end
        bus_idle();
        io_wr(8'h02);
        mem_wr(16'h2000);
        n_checks++;
        if (w_outs !== {4'b0011, 6'd2}) begin
            n_fails++; $display("FAIL mapram_bank2_write: got %b want %b", w_outs, {4'b0011, 6'd2});
        end
        bus_idle();
    endtask

    task automatic test_conmem_reset();
        io_wr(8'h83);
        mem_wr(16'h2000);
        n_checks++;
        if (w_outs !== {4'b0011, 6'd3}) begin
            n_fails++; $display("FAIL conmem_bank3_write: got %b want %b", w_outs, {4'b0011, 6'd3});
        end
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1101, HI}) begin
            n_fails++; $display("FAIL conmem_over_mapram: got %b want %b", w_outs, {4'b1101, HI});
        end
        mem_wr(16'h2000);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL async_reset_unmap: got %b want %b", w_outs, {4'b1110, HI});
        end
        clk_edge();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (w_outs !== {4'b1110, HI}) begin
            n_fails++; $display("FAIL after_reset_unmapped: got %b want %b", w_outs, {4'b1110, HI});
        end
        bus_idle();
        fetch_start(16'h0000);
        clk_edge();
        bus_idle();
        mem_rd(16'h0000);
        n_checks++;
        if (w_outs !== {4'b1101, HI}) begin
            n_fails++; $display("FAIL reset_cleared_mapram: got %b want %b", w_outs, {4'b1101, HI});
        end
        mem_rd(16'h2000);
        n_checks++;
        if (w_outs !== {4'b0111, 6'd0}) begin
            n_fails++; $display("FAIL reset_cleared_bank: got %b want %b", w_outs, {4'b0111, 6'd0});
        end
        bus_idle();
    endtask

    initial begin
        n_checks = 0; n_fails = 0;
        rst_n = 1'b0; a = 16'h0000; din = 8'h00;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        rom3e_cs = 1'b0; rom3e_hiaddr = HI; banco_rom = 2'b11; allramplus3 = 1'b0;
        test_reset();
        test_e3_edge();
        test_entry_trap();
        test_exit();
        test_instant();
        test_trap_disable();
        test_mapram();
        test_conmem_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
